aes_subbytes_seq: RTL and testbench

// Iterative SubBytes/InvSubBytes engine for a full 128-bit AES state.

---
 rtl/aes_subbytes_seq.sv | 170 +++++++++++++++++
 tb/tb_aes_subbytes_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subbytes_seq.sv
// Iterative SubBytes / InvSubBytes engine for a 128-bit AES state.
//
// LANES S-box lanes substitute LANES bytes of the working register per cycle,
// so a full state takes 16/LANES RUN cycles. Each lane holds a forward table
// and, when ENABLE_INV is set, an inverse table selected by the latched inv.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   start_i      request; sampled only while busy_o is low
//   inv_i        0 = SubBytes, 1 = InvSubBytes; captured with start_i
//   state_in_i   input state, byte0 = [127:120] ... byte15 = [7:0]
//   busy_o       engine running; start_i ignored while high
//   done_o       one-cycle pulse, state_out_o valid
//   state_out_o  substituted state; held until the next operation completes
module aes_subbytes_seq #(
    parameter int unsigned LANES      = 4,
    parameter bit          ENABLE_INV = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         inv_i,
    input  logic [127:0] state_in_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] state_out_o
);

    localparam int unsigned NumSteps = 16 / LANES;
    localparam int unsigned CntW     = (NumSteps > 1) ? $clog2(NumSteps) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumSteps - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gen_bad_lanes
        $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // Entry 0x00 sits in the top byte of each table.
    localparam logic [2047:0] SboxFwd = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SboxInv = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Table entry b lives at bit offset (255 - b) * 8 == {~b, 3'b000}.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SboxFwd[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SboxInv[{~b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            inv_q;
    logic            busy_q;
    logic            done_q;
    logic [127:0]    work_q;
    logic [127:0]    work_d;
    logic [127:0]    state_out_q;

    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    // Byte p of the state occupies bits [(15-p)*8 +: 8]; lane l handles byte cnt*LANES+l.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = work_q[(15 - (32'(cnt_q) * LANES + 32'(l))) * 8 +: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : gen_lane
        if (ENABLE_INV) begin : gen_fwd_inv
            assign lane_out[l] = inv_q ? sbox_inv(lane_in[l]) : sbox_fwd(lane_in[l]);
        end else begin : gen_fwd_only
            assign lane_out[l] = sbox_fwd(lane_in[l]);
        end
    end

    always_comb begin
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[(15 - (32'(cnt_q) * LANES + 32'(l))) * 8 +: 8] = lane_out[l];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            work_q      <= '0;
            state_out_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // DONE behaves like IDLE for acceptance so back-to-back starts need no gap.
                    done_q <= 1'b0;
                    if (start_i) begin
                        work_q  <= state_in_i;
                        inv_q   <= ENABLE_INV & inv_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        state_out_q <= work_d;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StDone;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign state_out_o = state_out_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Self-checking bench for aes_subbytes_seq. Instances 0..4 use LANES 1,2,4,8,16
// with inverse tables; instance 5 uses LANES=4 without them. The reference
// S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_subbytes_seq;

    localparam int NumDut = 6;

    logic         clk;
    logic         rst;
    logic         start [NumDut];
    logic         inv   [NumDut];
    logic [127:0] sin   [NumDut];
    logic         busy  [NumDut];
    logic         done  [NumDut];
    logic [127:0] sout  [NumDut];

    for (genvar g = 0; g < NumDut; g++) begin : gen_dut
        aes_subbytes_seq #(
            .LANES      ((g == 5) ? 4 : (1 << g)),
            .ENABLE_INV (g != 5)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .start_i     (start[g]),
            .inv_i       (inv[g]),
            .state_in_i  (sin[g]),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .state_out_o (sout[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];
    logic [127:0] sb_q [$];

    function automatic int n_of(input int idx);
        return 16 / ((idx == 5) ? 4 : (1 << idx));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic iv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[127 - 8 * k -: 8] = iv ? inv_t[d[127 - 8 * k -: 8]] : fwd_t[d[127 - 8 * k -: 8]];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation: drive start for one edge, scramble inputs afterwards,
    // wait (bounded) for done, check latency and scoreboard result.
    task automatic run_op(input int idx, input logic [127:0] data, input logic iv,
                          input string tag, output logic [127:0] res);
        int cyc;
        @(negedge clk);
        start[idx] = 1'b1;
        sin[idx]   = data;
        inv[idx]   = iv;
        sb_q.push_back(model(data, iv && (idx != 5)));
        @(posedge clk);
        #1;
        start[idx] = 1'b0;
        sin[idx]   = ~data;
        inv[idx]   = ~iv;
        cyc = 0;
        while (!done[idx] && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk($sformatf("%s_latency", tag), 128'(cyc), 128'(n_of(idx)));
        res = sout[idx];
        chk(tag, res, sb_q.pop_front());
    endtask

    initial begin
        logic [127:0] r1;
        logic [127:0] r2;
        logic [127:0] data;
        logic [127:0] a;
        logic [127:0] b;
        logic [7:0]   bi;
        logic [7:0]   s;
        int           cyc;
        int           seen;

        rst = 1'b1;
        for (int i = 0; i < NumDut; i++) begin
            start[i] = 1'b0;
            inv[i]   = 1'b0;
            sin[i]   = '0;
        end

        // Reference tables
        for (int v = 0; v < 256; v++) begin
            bi = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (v != 0 && gmul(8'(v), 8'(c)) == 8'h01) bi = 8'(c);
            end
            s = bi ^ rotl8(bi, 1) ^ rotl8(bi, 2) ^ rotl8(bi, 3) ^ rotl8(bi, 4) ^ 8'h63;
            fwd_t[v] = s;
            inv_t[s] = 8'(v);
        end

        #12;
        for (int i = 0; i < NumDut; i++) begin
            chk($sformatf("reset_busy%0d", i), 128'(busy[i]), 128'(0));
            chk($sformatf("reset_done%0d", i), 128'(done[i]), 128'(0));
            chk($sformatf("reset_out%0d", i), sout[i], 128'(0));
        end
        @(negedge clk);
        rst = 1'b0;

        // Known-answer vectors, LANES=4
        run_op(2, 128'h00112233445566778899aabbccddeeff, 1'b0, "kat_fwd", r1);
        chk("kat_fwd_const", r1, 128'h638293c31bfc33f5c4eeacea4bc12816);
        run_op(2, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, "kat_inv", r2);
        chk("kat_inv_const", r2, 128'h00112233445566778899aabbccddeeff);
        repeat (3) @(posedge clk);
        #1;
        chk("out_hold", sout[2], 128'h00112233445566778899aabbccddeeff);

        // Every byte value in every slot, forward then inverse, all lane counts
        for (int g = 0; g < 5; g++) begin
            for (int v = 0; v < 256; v++) begin
                for (int k = 0; k < 16; k++) data[127 - 8 * k -: 8] = 8'(v + 13 * k);
                run_op(g, data, 1'b0, $sformatf("ex_fwd_l%0d", g), r1);
                run_op(g, r1, 1'b1, $sformatf("ex_inv_l%0d", g), r2);
                chk($sformatf("ex_roundtrip_l%0d", g), r2, data);
            end
        end

        // Start held through RUN (with new data) is ignored, then accepted in DONE
        a = 128'h0123456789abcdeffedcba9876543210;
        b = 128'h5a5a5a5a00ff00ff123456789abcdef0;
        @(negedge clk);
        start[2] = 1'b1;
        sin[2]   = a;
        inv[2]   = 1'b0;
        sb_q.push_back(model(a, 1'b0));
        @(posedge clk);
        #1;
        sin[2] = b;
        inv[2] = 1'b1;
        sb_q.push_back(model(b, 1'b1));
        cyc = 0;
        while (!done[2] && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b_first_latency", 128'(cyc), 128'(4));
        chk("b2b_first", sout[2], sb_q.pop_front());
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                chk("b2b_accept_in_done", 128'(busy[2]), 128'(1));
                start[2] = 1'b0;
            end
        end while (!done[2] && cyc < 40);
        chk("b2b_second_gap", 128'(cyc), 128'(5));
        chk("b2b_second", sout[2], sb_q.pop_front());

        // Asynchronous reset mid-RUN
        @(negedge clk);
        start[2] = 1'b1;
        sin[2]   = a;
        inv[2]   = 1'b0;
        @(posedge clk);
        #1;
        start[2] = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_busy", 128'(busy[2]), 128'(0));
        chk("abort_done", 128'(done[2]), 128'(0));
        chk("abort_out", sout[2], 128'(0));
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done[2]) seen++;
        end
        chk("abort_no_done", 128'(seen), 128'(0));
        chk("abort_out_still_zero", sout[2], 128'(0));
        run_op(2, 128'(0), 1'b0, "after_abort", r1);
        chk("after_abort_const", r1, {16{8'h63}});

        // Forward-only build ignores inv
        run_op(5, 128'(0), 1'b1, "noinv_zero", r1);
        chk("noinv_zero_const", r1, {16{8'h63}});
        run_op(5, 128'h00112233445566778899aabbccddeeff, 1'b1, "noinv_kat", r1);
        chk("noinv_kat_const", r1, 128'h638293c31bfc33f5c4eeacea4bc12816);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
